// File: rtl/booth_seq_divider.sv
// ============================================================================
//  Module   : booth_seq_divider
//  Brief    : Sequential radix-2 restoring divider (A/Q shift-register datapath)
//             producing quotient, remainder, divide-by-zero and overflow flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module booth_seq_divider #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;

    assign w_dvd_neg = SIGNED && dividend[WIDTH-1];
    assign w_dvs_neg = SIGNED && divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    // One restoring step: shift the quotient MSB into A, then trial-subtract M.
    assign w_a_shift = (a_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    assign w_trial   = w_a_shift - {1'b0, m_q};
    assign w_fits    = (w_a_shift >= {1'b0, m_q});

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        q_d           = q_q;
        m_d           = m_q;
        cnt_d         = cnt_q;
        dvd_neg_d     = dvd_neg_q;
        dvs_neg_d     = dvs_neg_q;
        dbz_d         = dbz_q;
        ovf_d         = ovf_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    a_d           = '0;
                    cnt_d         = '0;
                    dvd_neg_d     = w_dvd_neg;
                    dvs_neg_d     = w_dvs_neg;
                    m_d           = w_dvs_mag;
                    dbz_d         = (divisor == '0);
                    ovf_d         = SIGNED && (dividend == MOST_NEG) && (&divisor);
                    if (divisor == '0) begin
                        // Raw dividend is parked in Q so FIX can return it as the remainder.
                        q_d     = dividend;
                        state_d = S_FIX;
                    end else begin
                        q_d     = w_dvd_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                a_d   = w_fits ? w_trial : w_a_shift;
                q_d   = {q_q[WIDTH-2:0], w_fits};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dbz_q) begin
                    quotient_d    = '1;
                    remainder_d   = q_q;
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                end else begin
                    // The most-negative / -1 case wraps naturally to MOST_NEG here.
                    quotient_d    = (dvd_neg_q ^ dvs_neg_q) ? (~q_q + 1'b1) : q_q;
                    remainder_d   = dvd_neg_q ? (~a_q[WIDTH-1:0] + 1'b1) : a_q[WIDTH-1:0];
                    div_by_zero_d = 1'b0;
                    overflow_d    = ovf_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            q_q           <= '0;
            m_q           <= '0;
            cnt_q         <= '0;
            dvd_neg_q     <= 1'b0;
            dvs_neg_q     <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            q_q           <= q_d;
            m_q           <= m_d;
            cnt_q         <= cnt_d;
            dvd_neg_q     <= dvd_neg_d;
            dvs_neg_q     <= dvs_neg_d;
            dbz_q         <= dbz_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_divider.sv
// ============================================================================
//  Module   : tb_booth_seq_divider
//  Brief    : Self-checking bench for booth_seq_divider, unsigned and signed
//             instances against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_booth_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_u, start_s;
    logic [7:0] dvd_u, dvs_u, dvd_s, dvs_s;
    logic       busy_u, done_u, dbz_u, ovf_u;
    logic       busy_s, done_s, dbz_s, ovf_s;
    logic [7:0] quo_u, rem_u, quo_s, rem_s;

    logic       sel_s;
    logic       w_busy, w_done, w_dbz, w_ovf;
    logic [7:0] w_quo, w_rem;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    booth_seq_divider #(.WIDTH(8), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start_u), .dividend(dvd_u), .divisor(dvs_u),
        .busy(busy_u), .done(done_u), .quotient(quo_u), .remainder(rem_u),
        .div_by_zero(dbz_u), .overflow(ovf_u)
    );

    booth_seq_divider #(.WIDTH(8), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start(start_s), .dividend(dvd_s), .divisor(dvs_s),
        .busy(busy_s), .done(done_s), .quotient(quo_s), .remainder(rem_s),
        .div_by_zero(dbz_s), .overflow(ovf_s)
    );

    assign w_busy = sel_s ? busy_s : busy_u;
    assign w_done = sel_s ? done_s : done_u;
    assign w_quo  = sel_s ? quo_s  : quo_u;
    assign w_rem  = sel_s ? rem_s  : rem_u;
    assign w_dbz  = sel_s ? dbz_s  : dbz_u;
    assign w_ovf  = sel_s ? ovf_s  : ovf_u;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {quotient, remainder, div_by_zero, overflow} from plain arithmetic.
    function automatic logic [17:0] ref_div(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        bit z, o;
        int sa, sb;
        z = 1'b0;
        o = 1'b0;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1;
        end else if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
                q = 8'h80; r = 8'h00; o = 1'b1;
            end else begin
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r, z, o};
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        if (sel_s) begin
            start_s = v; dvd_s = a; dvs_s = b;
        end else begin
            start_u = v; dvd_u = a; dvs_u = b;
        end
    endtask

    // One divide; optionally a second start (poke) is pulsed while the first is running.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int poke,
                           input logic [7:0] pa, input logic [7:0] pb, input string tag);
        logic [17:0] e;
        int lat;
        bit seen;
        bit extra;
        e     = ref_div(sel_s, a, b);
        lat   = (b == 8'd0) ? 2 : 10;
        seen  = 1'b0;
        extra = 1'b0;
        @(negedge clk);
        drive(1'b1, a, b);
        for (int n = 1; n <= 14 && !seen; n++) begin
            @(negedge clk);
            if (n == poke) drive(1'b1, pa, pb);
            else if (poke > 0) drive(1'b0, pa, pb);
            else drive(1'b0, a, b);
            chk({tag, " busy"}, 32'(w_busy), 32'(n < lat));
            chk({tag, " done"}, 32'(w_done), 32'(n == lat));
            if (w_done) begin
                seen = 1'b1;
                chk({tag, " quotient"}, 32'(w_quo), 32'(e[17:10]));
                chk({tag, " remainder"}, 32'(w_rem), 32'(e[9:2]));
                chk({tag, " div_by_zero"}, 32'(w_dbz), 32'(e[1]));
                chk({tag, " overflow"}, 32'(w_ovf), 32'(e[0]));
            end
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(w_done), 32'd0);
        chk({tag, " quotient held"}, 32'(w_quo), 32'(e[17:10]));
        if (poke > 0) begin
            repeat (12) begin
                @(negedge clk);
                if (w_done) extra = 1'b1;
            end
            chk({tag, " no second done"}, 32'(extra), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(w_busy), 32'd0);
        chk({tag, " done"}, 32'(w_done), 32'd0);
        chk({tag, " quotient"}, 32'(w_quo), 32'd0);
        chk({tag, " remainder"}, 32'(w_rem), 32'd0);
        chk({tag, " div_by_zero"}, 32'(w_dbz), 32'd0);
        chk({tag, " overflow"}, 32'(w_ovf), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit any_done;
        rst = 1'b1;
        start_u = 1'b0; start_s = 1'b0;
        dvd_u = 8'd0; dvs_u = 8'd0; dvd_s = 8'd0; dvs_s = 8'd0;
        sel_s = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sel_s = 1'b0; chk_zero("reset unsigned");
        sel_s = 1'b1; chk_zero("reset signed");

        sel_s = 1'b0; run_div(8'd100, 8'd7, 0, 8'd0, 8'd0, "u 100/7");
        sel_s = 1'b1; run_div(8'h9C, 8'h07, 0, 8'd0, 8'd0, "s -100/7");
        sel_s = 1'b1; run_div(8'd100, 8'hF9, 0, 8'd0, 8'd0, "s 100/-7");
        sel_s = 1'b1; run_div(8'h80, 8'hFF, 0, 8'd0, 8'd0, "s min/-1");
        sel_s = 1'b1; run_div(8'h80, 8'h01, 0, 8'd0, 8'd0, "s min/1");
        sel_s = 1'b0; run_div(8'h80, 8'hFF, 0, 8'd0, 8'd0, "u 128/255");
        sel_s = 1'b1; run_div(8'd5, 8'd0, 0, 8'd0, 8'd0, "s 5/0");
        sel_s = 1'b1; run_div(8'd9, 8'd3, 0, 8'd0, 8'd0, "s 9/3 after dbz");
        sel_s = 1'b0; run_div(8'd5, 8'd0, 0, 8'd0, 8'd0, "u 5/0");
        sel_s = 1'b0; run_div(8'd100, 8'd7, 4, 8'd9, 8'd3, "u start while busy");

        // Reset in the middle of 200/3 aborts it and clears the outputs.
        sel_s = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'd200, 8'd3);
        @(negedge clk);
        drive(1'b0, 8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("mid reset");
        any_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (w_done) any_done = 1'b1;
        end
        chk("mid reset no done", 32'(any_done), 32'd0);
        run_div(8'd200, 8'd3, 0, 8'd0, 8'd0, "u 200/3 after reset");

        for (int i = 0; i < 60; i++) begin
            sel_s = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 8'd0;
                1: begin ra = 8'h80; rb = 8'hFF; end
                2: ra = 8'h80;
                default: ;
            endcase
            run_div(ra, rb, 0, 8'd0, 8'd0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
